mlp_train_scheduler: RTL
========================

// Module: mlp_train_scheduler
// PURPOSE
//  Sequences MLP training and evaluation epochs. Holds a small labelled sample set and streams it
//  into the MLP: a training pass (training=1), then an evaluation pass (training=0). Scores each
//  evaluation prediction against a threshold and reports per-epoch and final classification counts.
//  Sits between the host/bench and the MLP's values/expected/training/prediction ports.
// PARAMETERS
//  W        64  sfp width (signed Q32.32; ONE=2^32, HALF=2^31)
//  INPUTS    2  features per sample (MLP input count)
//  SAMPLES   4  sample-set depth (>=1)
//  MLP_LAT   1  cycles from sample presented to its prediction valid (>=1)
// PORTS
//  clk            in   1                clock, rising edge
//  rst            in   1                reset, asynchronous, active-low
//  ld_en          in   1                write sample ld_addr (ignored while busy)
//  ld_addr        in   $clog2(SAMPLES)  sample index (max(1,...) bits)
//  ld_values      in   INPUTS*W         sample features, feature i at [i*W +: W]
//  ld_expected    in   W                sample label
//  start          in   1                begin run (sampled in IDLE only)
//  abort          in   1                cancel run
//  num_epochs     in   16               epoch count, latched at start
//  threshold      in   W                class boundary, latched at start (signed)
//  values         out  INPUTS*W         to MLP features
//  expected       out  W                to MLP label
//  training       out  1                to MLP: 1 = update weights this cycle
//  prediction     in   W                from MLP output 0
//  busy           out  1                run in progress
//  epoch          out  16               current epoch index
//  epoch_valid    out  1                1-cycle pulse: epoch_correct is valid
//  epoch_correct  out  $clog2(SAMPLES+1) correct classifications in finished epoch
//  done           out  1                1-cycle pulse: run complete
//  final_correct  out  $clog2(SAMPLES+1) epoch_correct of the last epoch, held until next start
// BEHAVIOUR
//  Reset (async, rst=0): all outputs 0; FSM=IDLE; sample memory contents undefined (not cleared).
//  All outputs are registered. values/expected/training change only on clk edges.
//  States: IDLE -> TRAIN -> EVAL -> DRAIN -> REPORT -> (TRAIN | FIN) -> IDLE.
//  IDLE: values/expected=0, training=0. start && num_epochs==0 -> FIN (final_correct=0).
//   start && num_epochs>0 -> TRAIN; idx=0, epoch=0, busy=1, latch num_epochs and threshold.
//  TRAIN: one sample per cycle, idx 0..SAMPLES-1, training=1. After idx=SAMPLES-1 -> EVAL, idx=0.
//  EVAL: one sample per cycle, training=0. Tag = (expected < threshold) enters an MLP_LAT-deep
//   delay line with a valid bit. After idx=SAMPLES-1 -> DRAIN.
//  Scoring: when the delayed valid is 1, if (prediction < threshold) == tag then correct++.
//   Comparisons are signed W-bit. prediction == threshold counts as class 1 (not less).
//  DRAIN: MLP_LAT cycles, training=0, values/expected=0; delay line empties; then REPORT.
//  REPORT (1 cycle): epoch_valid=1, epoch_correct=correct, correct cleared.
//   If epoch+1 == num_epochs -> FIN, else epoch++, -> TRAIN.
//  FIN (1 cycle): done=1, busy=0, final_correct=last epoch_correct; -> IDLE.
//  Epoch cost: 2*SAMPLES + MLP_LAT + 1 cycles. A sample presented at edge t is scored at t+MLP_LAT.
//  abort: priority over everything. Next edge -> IDLE, training=0, values/expected=0, busy=0,
//   delay line cleared, no done or epoch_valid pulse, final_correct unchanged.
//  start while busy: ignored. ld_en while busy: ignored; ld_en in IDLE writes on the same edge.
//  Reset mid-run: identical to abort, plus all outputs zeroed immediately.
//  correct counter saturates at SAMPLES; it cannot exceed this by construction.
// TESTING
//  1 Load XOR set (0,0->0)(0,1->ONE)(1,0->ONE)(1,1->0), thr=HALF, 3 epochs, mock MLP echoes
//    expected delayed MLP_LAT -> epoch_valid 3x with correct=4, done once, final_correct=4,
//    each epoch exactly 10 cycles (MLP_LAT=1).
//  2 Same set, mock returns ONE-expected -> every epoch_correct=0, final_correct=0.
//  3 Mock returns prediction==HALF for all samples -> class 1 everywhere -> correct=2.
//  4 num_epochs=0 -> done pulses 1 cycle after start, no TRAIN cycles, final_correct=0.
//  5 abort during 2nd epoch's EVAL -> IDLE next edge, training=0, busy=0, no done pulse;
//    a following start runs cleanly from epoch 0.
//  6 ld_en/start asserted while busy -> memory and run unchanged. rst low mid-TRAIN ->
//    all outputs 0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/mlp_train_scheduler.sv
// Streams a small labelled sample set into an MLP as alternating train/eval passes,
// scores each delayed eval prediction against a threshold and reports per-epoch counts.
module mlp_train_scheduler #(
   parameter int W       = 64,
   parameter int INPUTS  = 2,
   parameter int SAMPLES = 4,
   parameter int MLP_LAT = 1,
   parameter int AW      = (SAMPLES > 1) ? $clog2(SAMPLES) : 1,
   parameter int CW      = $clog2(SAMPLES + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ld_en,
   input  logic [AW-1:0]         ld_addr,
   input  logic [INPUTS*W-1:0]   ld_values,
   input  logic [W-1:0]          ld_expected,
   input  logic                  start,
   input  logic                  abort,
   input  logic [15:0]           num_epochs,
   input  logic [W-1:0]          threshold,
   output logic [INPUTS*W-1:0]   values,
   output logic [W-1:0]          expected,
   output logic                  training,
   input  logic [W-1:0]          prediction,
   output logic                  busy,
   output logic [15:0]           epoch,
   output logic                  epoch_valid,
   output logic [CW-1:0]         epoch_correct,
   output logic                  done,
   output logic [CW-1:0]         final_correct
);

   localparam int DW = (MLP_LAT > 1) ? $clog2(MLP_LAT) : 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_TRAIN  = 3'd1;
   localparam logic [2:0] S_EVAL   = 3'd2;
   localparam logic [2:0] S_DRAIN  = 3'd3;
   localparam logic [2:0] S_REPORT = 3'd4;
   localparam logic [2:0] S_FIN    = 3'd5;

   logic [INPUTS*W-1:0] mem_val [SAMPLES];
   logic [W-1:0]        mem_exp [SAMPLES];

   logic [2:0]          state_q, state_d;
   logic [AW-1:0]       idx_q, idx_d;
   logic [DW-1:0]       drain_q, drain_d;
   logic [15:0]         epoch_q, epoch_d;
   logic [15:0]         num_ep_q, num_ep_d;
   logic [W-1:0]        thr_q, thr_d;
   logic [CW-1:0]       correct_q, correct_d;
   logic [MLP_LAT-1:0]  dly_vld_q, dly_vld_d;
   logic [MLP_LAT-1:0]  dly_tag_q, dly_tag_d;
   logic [INPUTS*W-1:0] values_q, values_d;
   logic [W-1:0]        expected_q, expected_d;
   logic                training_q, training_d;
   logic                busy_q, busy_d;
   logic                epoch_valid_q, epoch_valid_d;
   logic [CW-1:0]       epoch_correct_q, epoch_correct_d;
   logic                done_q, done_d;
   logic [CW-1:0]       final_correct_q, final_correct_d;

   logic                pres, push, hit;
   logic [AW-1:0]       rd_idx;

   // Sample memory is deliberately not reset.
   always_ff @(posedge clk) begin
      if (ld_en && state_q == S_IDLE) begin
         mem_val[ld_addr] <= ld_values;
         mem_exp[ld_addr] <= ld_expected;
      end
   end

   assign hit = dly_vld_q[MLP_LAT-1] &&
                (($signed(prediction) < $signed(thr_q)) == dly_tag_q[MLP_LAT-1]);

   always_comb begin
      state_d         = state_q;
      idx_d           = idx_q;
      drain_d         = drain_q;
      epoch_d         = epoch_q;
      num_ep_d        = num_ep_q;
      thr_d           = thr_q;
      correct_d       = correct_q;
      busy_d          = busy_q;
      epoch_correct_d = epoch_correct_q;
      final_correct_d = final_correct_q;
      values_d        = '0;
      expected_d      = '0;
      training_d      = 1'b0;
      epoch_valid_d   = 1'b0;
      done_d          = 1'b0;
      pres            = 1'b0;
      push            = 1'b0;
      rd_idx          = '0;

      if (hit && correct_q != CW'(SAMPLES)) correct_d = correct_q + CW'(1);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (num_epochs == 16'd0) begin
                  state_d         = S_FIN;
                  done_d          = 1'b1;
                  final_correct_d = '0;
               end else begin
                  state_d    = S_TRAIN;
                  idx_d      = '0;
                  epoch_d    = '0;
                  busy_d     = 1'b1;
                  num_ep_d   = num_epochs;
                  thr_d      = threshold;
                  correct_d  = '0;
                  pres       = 1'b1;
                  training_d = 1'b1;
               end
            end
         end
         S_TRAIN: begin
            pres = 1'b1;
            if (idx_q == AW'(SAMPLES - 1)) begin
               state_d = S_EVAL;
               idx_d   = '0;
               push    = 1'b1;
            end else begin
               idx_d      = idx_q + AW'(1);
               rd_idx     = idx_q + AW'(1);
               training_d = 1'b1;
            end
         end
         S_EVAL: begin
            if (idx_q == AW'(SAMPLES - 1)) begin
               state_d = S_DRAIN;
               drain_d = '0;
            end else begin
               idx_d  = idx_q + AW'(1);
               rd_idx = idx_q + AW'(1);
               pres   = 1'b1;
               push   = 1'b1;
            end
         end
         S_DRAIN: begin
            if (drain_q == DW'(MLP_LAT - 1)) begin
               state_d         = S_REPORT;
               epoch_valid_d   = 1'b1;
               epoch_correct_d = correct_d;
               correct_d       = '0;
            end else begin
               drain_d = drain_q + DW'(1);
            end
         end
         S_REPORT: begin
            if (epoch_q + 16'd1 == num_ep_q) begin
               state_d         = S_FIN;
               done_d          = 1'b1;
               busy_d          = 1'b0;
               final_correct_d = epoch_correct_q;
            end else begin
               state_d    = S_TRAIN;
               epoch_d    = epoch_q + 16'd1;
               idx_d      = '0;
               pres       = 1'b1;
               training_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (pres) begin
         values_d   = mem_val[rd_idx];
         expected_d = mem_exp[rd_idx];
      end

      // Tag records the label's class as the sample enters the MLP.
      dly_vld_d[0] = push;
      dly_tag_d[0] = push && ($signed(mem_exp[rd_idx]) < $signed(thr_q));
      for (int k = 1; k < MLP_LAT; k++) begin
         dly_vld_d[k] = dly_vld_q[k-1];
         dly_tag_d[k] = dly_tag_q[k-1];
      end

      if (abort) begin
         state_d         = S_IDLE;
         idx_d           = '0;
         epoch_d         = '0;
         correct_d       = '0;
         busy_d          = 1'b0;
         values_d        = '0;
         expected_d      = '0;
         training_d      = 1'b0;
         epoch_valid_d   = 1'b0;
         done_d          = 1'b0;
         final_correct_d = final_correct_q;
         dly_vld_d       = '0;
         dly_tag_d       = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= S_IDLE;
         idx_q           <= '0;
         drain_q         <= '0;
         epoch_q         <= '0;
         num_ep_q        <= '0;
         thr_q           <= '0;
         correct_q       <= '0;
         dly_vld_q       <= '0;
         dly_tag_q       <= '0;
         values_q        <= '0;
         expected_q      <= '0;
         training_q      <= 1'b0;
         busy_q          <= 1'b0;
         epoch_valid_q   <= 1'b0;
         epoch_correct_q <= '0;
         done_q          <= 1'b0;
         final_correct_q <= '0;
      end else begin
         state_q         <= state_d;
         idx_q           <= idx_d;
         drain_q         <= drain_d;
         epoch_q         <= epoch_d;
         num_ep_q        <= num_ep_d;
         thr_q           <= thr_d;
         correct_q       <= correct_d;
         dly_vld_q       <= dly_vld_d;
         dly_tag_q       <= dly_tag_d;
         values_q        <= values_d;
         expected_q      <= expected_d;
         training_q      <= training_d;
         busy_q          <= busy_d;
         epoch_valid_q   <= epoch_valid_d;
         epoch_correct_q <= epoch_correct_d;
         done_q          <= done_d;
         final_correct_q <= final_correct_d;
      end
   end

   assign values        = values_q;
   assign expected      = expected_q;
   assign training      = training_q;
   assign busy          = busy_q;
   assign epoch         = epoch_q;
   assign epoch_valid   = epoch_valid_q;
   assign epoch_correct = epoch_correct_q;
   assign done          = done_q;
   assign final_correct = final_correct_q;

endmodule
